frame_deparser: RTL and testbench

Transmit-side counterpart of the ingress frame parser. Accepts 134-bit packet words from the packet-buffer read path and serializes them into the 9-bit byte stream consumed by the network output port, one byte per clock. It enforces a programmable inter-frame gap and reports sequencing errors. It sits in the network output process, between the packet-buffer reader and the port transmit interface.

---
 rtl/frame_deparser_pkg.sv | 45 ++++
 rtl/frame_deparser_pkt_word_fifo2.sv | 58 +++++
 rtl/frame_deparser.sv | 184 ++++++++++++++++++
 tb/tb_frame_deparser.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_deparser_pkg.sv
// Shared definitions for the frame deparser: packet-word layout, word types,
// FSM state encodings and small helpers for byte extraction.
package frame_deparser_pkg;

   localparam int PKT_W          = 134;
   localparam int DATA_W         = 9;
   localparam int BYTES_PER_WORD = 16;

   // Packet word type, carried in iv_pkt[133:132]
   typedef enum logic [1:0] {
      WT_INV  = 2'b00,
      WT_HEAD = 2'b01,
      WT_TAIL = 2'b10,
      WT_MID  = 2'b11
   } word_type_e;

   // Deparser FSM states, exported on the debug port
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SEND = 2'b01,
      ST_GAP  = 2'b10
   } dep_state_e;

   // Word type field of a packet word
   function automatic word_type_e word_type(input logic [PKT_W-1:0] w);
      return word_type_e'(w[133:132]);
   endfunction

   // Byte idx of the data field; byte 0 sits at [127:120]
   function automatic logic [7:0] word_byte(input logic [PKT_W-1:0] w,
                                            input logic [3:0]       idx);
      logic [127:0] shifted;
      shifted = w[127:0] << {idx, 3'b000};
      return shifted[127:120];
   endfunction

   // Index of the last valid byte: tails drop their invalid-byte count
   function automatic logic [3:0] last_idx(input logic [PKT_W-1:0] w);
      if (word_type(w) == WT_TAIL) begin
         return 4'd15 - w[131:128];
      end
      return 4'd15;
   endfunction

endpackage

// File: rtl/frame_deparser_pkt_word_fifo2.sv
// Two-entry packet-word FIFO. The head entry is always visible on rd_data_o;
// a write and a read in the same cycle are both honoured. Writes while full
// and reads while empty are dropped.
module pkt_word_fifo2
   import frame_deparser_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en_i,
   input  logic [PKT_W-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [PKT_W-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [PKT_W-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic             wr_fire;
   logic             rd_fire;

   assign full_o    = (count_q == 2'd2);
   assign empty_o   = (count_q == 2'd0);
   assign wr_fire   = wr_en_i & ~full_o;
   assign rd_fire   = rd_en_i & ~empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];

   // Word storage; entry validity is tracked by count_q so no reset is needed
   always_ff @(posedge clk_i) begin
      if (wr_fire) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (wr_fire) begin
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (rd_fire) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({wr_fire, rd_fire})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/frame_deparser.sv
// Frame deparser: serialises 134-bit packet words into a 9-bit byte stream,
// one byte per clock, flagging first/last bytes, enforcing an inter-frame gap
// and reporting word-sequence violations. All outputs are registered.
module frame_deparser
   import frame_deparser_pkg::*;
#(
   parameter int unsigned IFG_CYCLES = 12
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic [PKT_W-1:0]  iv_pkt,
   input  logic              i_pkt_wr,
   output logic              o_pkt_ready,
   output logic [DATA_W-1:0] ov_data,
   output logic              o_data_wr,
   output logic              o_frame_done_pulse,
   output logic              o_frame_err_pulse,
   output logic [1:0]        deparser_state
);

   localparam logic [7:0] IFG_M1 = 8'(IFG_CYCLES - 1);

   // FIFO interface
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic [PKT_W-1:0] fifo_rd_data;
   word_type_e       fifo_type;

   // FSM state
   dep_state_e       state_q;
   logic [PKT_W-1:0] word_q;       // word being sent, or head retained across a gap
   logic [3:0]       idx_q;        // index of the next byte of word_q to emit
   logic             have_word_q;  // word_q still has bytes to emit
   logic             head_pend_q;  // word_q holds a head that starts after the gap
   logic [7:0]       gap_cnt_q;

   // Registered outputs
   logic [DATA_W-1:0] data_q;
   logic              data_wr_q;
   logic              done_q;
   logic              err_q;

   // Decoded properties of the current word
   logic word_last;
   logic word_is_tail;
   logic byte_flag;
   logic wr_violation;

   pkt_word_fifo2 u_fifo (
      .clk_i     (clk_sys),
      .rst_ni    (reset_n),
      .wr_en_i   (i_pkt_wr),
      .wr_data_i (iv_pkt),
      .rd_en_i   (fifo_pop),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign fifo_type    = word_type(fifo_rd_data);
   assign word_last    = (idx_q == last_idx(word_q));
   assign word_is_tail = (word_type(word_q) == WT_TAIL);
   // Boundary flag: byte 0 of the head word and the last byte of the tail word
   assign byte_flag    = ((word_type(word_q) == WT_HEAD) && (idx_q == 4'd0)) ||
                         (word_is_tail && word_last);
   // A write while the FIFO is full is dropped and reported
   assign wr_violation = i_pkt_wr & fifo_full;

   // Pop decision: in IDLE whenever a word is waiting; in SEND when the current
   // non-tail word is finishing this cycle or already finished
   always_comb begin
      fifo_pop = 1'b0;
      if (!fifo_empty) begin
         case (state_q)
            ST_IDLE: fifo_pop = 1'b1;
            ST_SEND: fifo_pop = !have_word_q || (word_last && !word_is_tail);
            default: fifo_pop = 1'b0;
         endcase
      end
   end

   // Deparser FSM with registered byte-stream and status outputs
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         word_q      <= '0;
         idx_q       <= 4'd0;
         have_word_q <= 1'b0;
         head_pend_q <= 1'b0;
         gap_cnt_q   <= 8'd0;
         data_q      <= '0;
         data_wr_q   <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         data_wr_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= wr_violation;
         case (state_q)
            ST_IDLE: begin
               if (fifo_pop) begin
                  if (fifo_type == WT_HEAD) begin
                     // Emit byte 0 straight from the FIFO head to save a cycle
                     data_q      <= {1'b1, word_byte(fifo_rd_data, 4'd0)};
                     data_wr_q   <= 1'b1;
                     word_q      <= fifo_rd_data;
                     idx_q       <= 4'd1;
                     have_word_q <= 1'b1;
                     state_q     <= ST_SEND;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end

            ST_SEND: begin
               if (have_word_q) begin
                  data_q    <= {byte_flag, word_byte(word_q, idx_q)};
                  data_wr_q <= 1'b1;
                  if (word_last) begin
                     have_word_q <= 1'b0;
                     if (word_is_tail) begin
                        done_q    <= 1'b1;
                        gap_cnt_q <= IFG_M1;
                        state_q   <= ST_GAP;
                     end
                  end else begin
                     idx_q <= idx_q + 4'd1;
                  end
               end
               if (fifo_pop) begin
                  case (fifo_type)
                     WT_MID, WT_TAIL: begin
                        word_q      <= fifo_rd_data;
                        idx_q       <= 4'd0;
                        have_word_q <= 1'b1;
                     end
                     WT_HEAD: begin
                        // Missing tail: drop the rest of this frame, keep the new head
                        err_q       <= 1'b1;
                        word_q      <= fifo_rd_data;
                        idx_q       <= 4'd0;
                        head_pend_q <= 1'b1;
                        gap_cnt_q   <= IFG_M1;
                        state_q     <= ST_GAP;
                     end
                     default: begin
                        err_q <= 1'b1;
                     end
                  endcase
               end
            end

            ST_GAP: begin
               if (gap_cnt_q == 8'd0) begin
                  if (head_pend_q) begin
                     head_pend_q <= 1'b0;
                     have_word_q <= 1'b1;
                     idx_q       <= 4'd0;
                     state_q     <= ST_SEND;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q - 8'd1;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_pkt_ready        = ~fifo_full;
   assign ov_data            = data_q;
   assign o_data_wr          = data_wr_q;
   assign o_frame_done_pulse = done_q;
   assign o_frame_err_pulse  = err_q;
   assign deparser_state     = state_q;

endmodule

// File: tb/tb_frame_deparser.sv
// Testbench for frame_deparser: directed scenarios plus randomized frames.
// Words accepted by the DUT are fed to a frame-level reference model that
// queues expected bytes; a negedge monitor pops and compares every output byte.
module tb_frame_deparser;

   localparam int IFG = 12;

   logic         clk_sys;
   logic         reset_n;
   logic [133:0] iv_pkt;
   logic         i_pkt_wr;
   logic         o_pkt_ready;
   logic [8:0]   ov_data;
   logic         o_data_wr;
   logic         o_frame_done_pulse;
   logic         o_frame_err_pulse;
   logic [1:0]   deparser_state;

   typedef struct {
      logic [8:0] data;
      bit         done;
      bit         first;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_err = 0;
   int   obs_err = 0;
   int   cyc = 0;
   int   last_wr_cyc = -1;
   int   first_cyc = 0;
   int   done_cyc = 0;
   bit   in_frame = 0;

   frame_deparser #(.IFG_CYCLES(IFG)) dut (
      .clk_sys            (clk_sys),
      .reset_n            (reset_n),
      .iv_pkt             (iv_pkt),
      .i_pkt_wr           (i_pkt_wr),
      .o_pkt_ready        (o_pkt_ready),
      .ov_data            (ov_data),
      .o_data_wr          (o_data_wr),
      .o_frame_done_pulse (o_frame_done_pulse),
      .o_frame_err_pulse  (o_frame_err_pulse),
      .deparser_state     (deparser_state)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   // Monitor: one line per output byte that mismatches; counts err pulses
   always @(negedge clk_sys) begin
      if (!reset_n) begin
         exp_q.delete();
         last_wr_cyc = -1;
      end else begin
         if (o_frame_err_pulse) obs_err++;
         if (o_data_wr) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL byte_unexpected: got data=%03h done=%0b, expected no byte (cycle %0d)",
                        ov_data, o_frame_done_pulse, cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (ov_data !== e.data || o_frame_done_pulse !== e.done) begin
                  errors++;
                  $display("FAIL byte: got data=%03h done=%0b, expected data=%03h done=%0b (cycle %0d)",
                           ov_data, o_frame_done_pulse, e.data, e.done, cyc);
               end
               if (e.first) begin
                  if (last_wr_cyc >= 0) begin
                     checks++;
                     if (cyc - last_wr_cyc < IFG + 1) begin
                        errors++;
                        $display("FAIL ifg: got %0d idle cycles, expected at least %0d",
                                 cyc - last_wr_cyc - 1, IFG);
                     end
                  end
                  first_cyc = cyc;
               end
               if (e.done) done_cyc = cyc;
            end
            last_wr_cyc = cyc;
         end else if (o_frame_done_pulse) begin
            checks++;
            errors++;
            $display("FAIL done_without_byte: got done=1 with o_data_wr=0, expected done=0 (cycle %0d)", cyc);
         end
      end
   end

   // Frame-level reference: interprets the accepted word sequence
   task automatic model_word(input logic [133:0] w);
      int nbytes;
      case (w[133:132])
         2'b01: begin
            if (in_frame) exp_err++;   // head while a frame is open: old frame truncated
            in_frame = 1;
            nbytes   = 16;
         end
         2'b11: begin
            if (!in_frame) begin exp_err++; return; end
            nbytes = 16;
         end
         2'b10: begin
            if (!in_frame) begin exp_err++; return; end
            nbytes = 16 - int'(w[131:128]);
         end
         default: begin exp_err++; return; end
      endcase
      for (int i = 0; i < nbytes; i++) begin
         exp_t e;
         logic [7:0] b;
         b       = w[127 - 8*i -: 8];
         e.first = (w[133:132] == 2'b01) && (i == 0);
         e.done  = (w[133:132] == 2'b10) && (i == nbytes - 1);
         e.data  = {e.first || e.done, b};
         exp_q.push_back(e);
      end
      if (w[133:132] == 2'b10) in_frame = 0;
   endtask

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic logic [133:0] mk_word(input logic [1:0] t, input logic [3:0] inv);
      return {t, inv, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Write one word once the DUT is ready; returns the cycle it was driven in
   task automatic send_word(input logic [133:0] w, output int wcyc);
      int guard = 0;
      while (!o_pkt_ready && guard < 2000) begin
         @(posedge clk_sys); #1;
         guard++;
      end
      if (!o_pkt_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got o_pkt_ready=0 for %0d cycles, expected 1", guard);
         wcyc = cyc;
         return;
      end
      wcyc     = cyc;
      iv_pkt   = w;
      i_pkt_wr = 1'b1;
      model_word(w);
      @(posedge clk_sys); #1;
      i_pkt_wr = 1'b0;
   endtask

   task automatic send_frame(input int nmid, input int inv, input bit with_tail,
                             input int stall_tail, input int max_stall);
      int c;
      send_word(mk_word(2'b01, 4'd0), c);
      for (int m = 0; m < nmid; m++) begin
         repeat ($urandom_range(0, max_stall)) @(posedge clk_sys);
         #0;
         send_word(mk_word(2'b11, 4'd0), c);
      end
      if (with_tail) begin
         repeat (stall_tail) @(posedge clk_sys);
         if (stall_tail > 0) #1;
         send_word(mk_word(2'b10, 4'(inv)), c);
      end
   endtask

   // Wait for all expected bytes, then let err pulses settle and compare them
   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 4000) begin
         @(posedge clk_sys);
         n++;
      end
      #1;
      check({name, "_drain_left"}, exp_q.size(), 0);
      repeat (IFG + 20) @(posedge clk_sys);
      #1;
      check({name, "_err_pulses"}, obs_err, exp_err);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_ready"},   int'(o_pkt_ready), 1);
      check({name, "_data"},    int'(ov_data), 0);
      check({name, "_data_wr"}, int'(o_data_wr), 0);
      check({name, "_done"},    int'(o_frame_done_pulse), 0);
      check({name, "_err"},     int'(o_frame_err_pulse), 0);
      check({name, "_state"},   int'(deparser_state), 0);
   endtask

   initial begin
      int c_head;
      int c;
      reset_n  = 1'b0;
      i_pkt_wr = 1'b0;
      iv_pkt   = '0;
      repeat (3) @(posedge clk_sys);
      #1;
      check_reset_outputs("reset");
      reset_n = 1'b1;
      @(posedge clk_sys); #1;

      // 64-byte frame written back to back
      send_word(mk_word(2'b01, 4'd0), c_head);
      send_word(mk_word(2'b11, 4'd0), c);
      send_word(mk_word(2'b11, 4'd0), c);
      send_word(mk_word(2'b10, 4'd0), c);
      drain("f64");
      check("f64_latency", first_cyc - c_head, 2);
      check("f64_span", done_cyc - first_cyc, 63);

      // 60-byte frame (tail with 4 invalid bytes)
      send_frame(2, 4, 1, 0, 0);
      drain("f60");
      check("f60_span", done_cyc - first_cyc, 59);

      // 5-cycle upstream stall before the tail
      send_frame(2, 7, 1, 5, 0);
      drain("stall");

      // Stray middle word while idle, then a valid frame
      send_word(mk_word(2'b11, 4'd0), c);
      send_frame(1, 3, 1, 0, 0);
      drain("stray");

      // Head arriving before the tail of the previous frame
      send_frame(1, 0, 0, 0, 0);
      send_frame(2, 9, 1, 0, 0);
      drain("trunc");

      // Write while the FIFO is full: ignored and reported
      send_word(mk_word(2'b01, 4'd0), c);
      send_word(mk_word(2'b11, 4'd0), c);
      send_word(mk_word(2'b11, 4'd0), c);
      check("full_ready", int'(o_pkt_ready), 0);
      if (!o_pkt_ready) begin
         iv_pkt   = mk_word(2'b01, 4'd0);
         i_pkt_wr = 1'b1;
         exp_err++;
         @(posedge clk_sys); #1;
         i_pkt_wr = 1'b0;
      end
      send_word(mk_word(2'b10, 4'd2), c);
      drain("overflow");

      // Reset asserted mid-SEND for 3 cycles
      send_word(mk_word(2'b01, 4'd0), c);
      send_word(mk_word(2'b11, 4'd0), c);
      repeat (6) @(posedge clk_sys);
      #1;
      reset_n  = 1'b0;
      in_frame = 0;
      #1;
      check_reset_outputs("midreset");
      repeat (3) @(posedge clk_sys);
      #1;
      reset_n = 1'b1;
      @(posedge clk_sys); #1;
      send_frame(1, 5, 1, 0, 0);
      drain("postreset");

      // Randomized frames with stalls, stray words and occasional truncation
      for (int f = 0; f < 30; f++) begin
         if ($urandom_range(0, 7) == 0) begin
            logic [1:0] st;
            st = 2'($urandom_range(0, 2));
            if (st == 2'b01) st = 2'b11;
            send_word(mk_word(st, 4'($urandom_range(0, 15))), c);
         end
         send_frame($urandom_range(0, 3), $urandom_range(0, 15),
                    (f == 29) || ($urandom_range(0, 7) != 0),
                    $urandom_range(0, 3), 3);
      end
      drain("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
